data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder on the pipeline's memory-access port: answers ce/we/sel/addr/data requests from the MEM stage.
//  Byte-lane writes, fixed-latency reads with a stall handshake back to the pipeline, out-of-range address flagging.
//  Sits between the MEM stage and on-chip block RAM.
// PARAMETERS
//  AW        10  word-address width; DEPTH = 2**AW words (4*DEPTH bytes)
//  READ_LAT  2   read latency in cycles (1..7); cycles stall_o is held per read
//  MMIO_BASE 32'h1FAF_0000  base of MMIO window (used only with DMEM_MMIO_EN)
// PORTS
//  cpu_clk_50M  in   1   clock, rising edge
//  cpu_rst_n    in   1   asynchronous reset, active-low
//  ce_i         in   1   request valid (chip enable)
//  we_i         in   1   1 = write, 0 = read
//  sel_i        in   4   byte enables; bit k <-> data[8k+7:8k]
//  addr_i       in   32  byte address; held stable by requester while stall_o=1
//  wdata_i      in   32  write data, lane-aligned by requester
//  rdata_o      out  32  read data, full word (requester extracts lanes)
//  stall_o      out  1   1 = read in progress, requester must hold request
//  addr_err_o   out  1   1-cycle pulse: request addressed outside DEPTH
//  led_o        out  16  MMIO LED register (only with DMEM_MMIO_EN)
//  sw_i         in   16  MMIO switch input (only with DMEM_MMIO_EN)
// BEHAVIOUR
//  Reset (cpu_rst_n=0, async): state IDLE, rdata_o=0, stall_o=0, addr_err_o=0, wait counter=0, led_o=0, cycle counter=0. RAM contents not reset.
//  Decode: word index = addr_i[AW+1:2]; in range iff addr_i[31:AW+2]==0 (after MMIO check); addr_i[1:0] ignored.
//  Write: accepted in IDLE when ce_i&we_i; enabled lanes committed at that clock edge; no stall; sel_i=0 is a no-op.
//  Read FSM: IDLE -> WAIT on ce_i&~we_i (counter loads READ_LAT-1); WAIT decrements; at 0 -> RESP; RESP -> IDLE.
//  stall_o = ce_i & ~we_i & (state!=RESP); read issued cycle N: stall_o=1 for N..N+READ_LAT-1; at N+READ_LAT rdata_o valid, stall_o=0.
//  READ_LAT=1: IDLE -> RESP directly. rdata_o holds last read value until next RESP; it is not cleared in IDLE.
//  Flush: ce_i drops in WAIT/RESP -> stall_o=0 same cycle (combinational), FSM returns to IDLE next edge, result discarded.
//  Read-after-write same word: write commits before read starts; read returns new data.
//  Back-to-back reads: cycle after RESP is IDLE; a still-asserted ce_i is a new request (pipeline has advanced).
//  Out of range: write dropped; read runs full latency, returns 32'h0; addr_err_o=1 in accept cycle (write) or RESP cycle (read).
//  Reset mid-read: FSM to IDLE immediately, stall_o=0; no partial write possible (writes are single-edge).
// CONFIGURATION
//  DMEM_MMIO_EN defined: addr_i[31:16]==MMIO_BASE[31:16] routes to registers, bypassing RAM and range check:
//    +0x0 LED (rw, lanes 0..1 -> led_o), +0x4 switches (ro, {16'h0,sw_i}), +0x8 cycle counter (ro, 32-bit free-running, any write clears)
//    other offsets: read 0, write ignored, no addr_err_o. MMIO reads use same FSM and READ_LAT.
//  DMEM_MMIO_EN undefined: no led_o/sw_i ports, no counter; such addresses decode as ordinary (out-of-range) addresses.
// STRUCTURE
//  defines.v: RstEnable, ChipEnable/ChipDisable, WriteEnable/WriteDisable, ZeroWord, FSM state encodings DMEM_IDLE/WAIT/RESP, MMIO offsets.
//  Sub-module dmem_bank: 4 byte-wide arrays of DEPTH, per-lane write enable, registered read port; no reset on arrays.
//  Top: FSM, latency counter, decode, error pulse, optional MMIO block.
// TESTING
//  Write 32'hDEADBEEF sel 1111 @0x10, then read @0x10 -> stall_o high 2 cycles (READ_LAT=2), rdata_o=32'hDEADBEEF cycle 3, stall_o=0.
//  Write 32'h0000AA00 sel 0010 @0x10 over prior word -> read returns 32'hDEADAAEF.
//  Read @0x0000_1000 (AW=10) -> 32'h0 after READ_LAT, addr_err_o single-cycle pulse in RESP; write there -> pulse, RAM unchanged.
//  Read issued, ce_i dropped in first WAIT cycle -> stall_o=0 that cycle, IDLE next, rdata_o unchanged.
//  Reset asserted mid-WAIT -> stall_o=0, rdata_o=0 immediately; post-reset read of written word returns stored data.
//  DMEM_MMIO_EN: write 32'h0000_5A5A @MMIO_BASE -> led_o=16'h5A5A; sw_i=16'h00F0 read @+0x4 -> 32'h0000_00F0; write @+0x8, read after k cycles -> counter ~k.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// The FSM state encoding and the common zero word live here so the top and
// any future companions agree on them.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/data_mem_responder_bank.sv
// Byte-lane RAM bank for the data-memory responder.
// Four byte-wide arrays of 2**AW entries, one write enable per lane and a
// registered read port that only updates when re is asserted, so the last
// read word stays on rdata. The arrays are never reset.
module data_mem_responder_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    // Per-lane write and enabled registered read
    always_ff @(posedge clk) begin
      if (we[k]) mem[waddr] <= wdata[8*k +: 8];
      if (re)    q          <= mem[raddr];
    end

    assign rdata[8*k +: 8] = q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: single-edge byte-lane writes,
// fixed-latency reads with a stall handshake, out-of-range flagging.
// Optional MMIO window (LED register, switches, cycle counter) is enabled by
// defining DMEM_MMIO_EN; without it the led_o/sw_i ports and MMIO_BASE
// parameter do not exist and those addresses are ordinary (out of range).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int AW       = 10,
  parameter int READ_LAT = 2
`ifdef DMEM_MMIO_EN
  ,
  parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000
`endif
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        addr_err_o
`ifdef DMEM_MMIO_EN
  ,
  output logic [15:0] led_o,
  input  logic [15:0] sw_i
`endif
);

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  dmem_state_e   state;
  logic [2:0]    wait_cnt;
  logic          use_ram;
  logic [31:0]   alt_data;
  logic          err_q;
  logic [31:0]   bank_rdata;
  logic [31:0]   mmio_rdata;
  logic          is_mmio;

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          ram_sel;
  logic          out_of_range;
  logic          rd_req;
  logic          wr_acc;
  logic          rd_load;
  logic          unused_addr_lsb;

  assign word_idx        = addr_i[AW+1:2];
  assign in_range        = (addr_i[31:AW+2] == '0);
  assign ram_sel         = in_range & ~is_mmio;
  assign out_of_range    = ~in_range & ~is_mmio;
  assign unused_addr_lsb = ^addr_i[1:0];

  assign rd_req  = ce_i & ~we_i;
  assign wr_acc  = (state == DMEM_IDLE) & ce_i & we_i;
  // rd_load marks the edge that moves the FSM into RESP; the response is captured there
  assign rd_load = rd_req &
                   (((state == DMEM_IDLE) && (READ_LAT == 1)) ||
                    ((state == DMEM_WAIT) && (wait_cnt == 3'd1)));

  assign stall_o    = cpu_rst_n & rd_req & (state != DMEM_RESP);
  assign addr_err_o = cpu_rst_n & ((wr_acc & out_of_range) | err_q);
  assign rdata_o    = use_ram ? bank_rdata : alt_data;

  data_mem_responder_bank #(.AW(AW)) u_bank (
    .clk   (cpu_clk_50M),
    .we    ((wr_acc & ram_sel) ? sel_i : 4'b0000),
    .waddr (word_idx),
    .wdata (wdata_i),
    .re    (rd_load & ram_sel),
    .raddr (word_idx),
    .rdata (bank_rdata)
  );

  // Read FSM, latency counter, response source capture and read error pulse
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state    <= DMEM_IDLE;
      wait_cnt <= 3'd0;
      use_ram  <= 1'b0;
      alt_data <= ZERO_WORD;
      err_q    <= 1'b0;
    end else begin
      err_q <= rd_load & out_of_range;
      if (rd_load) begin
        use_ram  <= ram_sel;
        alt_data <= is_mmio ? mmio_rdata : ZERO_WORD;
      end
      case (state)
        DMEM_IDLE: begin
          if (rd_req) begin
            if (READ_LAT == 1) begin
              state <= DMEM_RESP;
            end else begin
              state    <= DMEM_WAIT;
              wait_cnt <= LAT_M1;
            end
          end
        end
        DMEM_WAIT: begin
          if (!rd_req) begin
            state    <= DMEM_IDLE;
            wait_cnt <= 3'd0;
          end else if (wait_cnt == 3'd1) begin
            state    <= DMEM_RESP;
            wait_cnt <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DMEM_RESP: state <= DMEM_IDLE;
        default:   state <= DMEM_IDLE;
      endcase
    end
  end

`ifdef DMEM_MMIO_EN
  localparam logic [15:0] MMIO_PAGE    = MMIO_BASE[31:16];
  localparam logic [15:0] MMIO_LED_OFS = 16'h0000;
  localparam logic [15:0] MMIO_SW_OFS  = 16'h0004;
  localparam logic [15:0] MMIO_CNT_OFS = 16'h0008;

  logic [15:0] mmio_ofs;
  logic [31:0] cycle_cnt;

  assign is_mmio  = (addr_i[31:16] == MMIO_PAGE);
  assign mmio_ofs = {addr_i[15:2], 2'b00};

  // MMIO register read mux; unmapped offsets read as zero
  always_comb begin
    mmio_rdata = ZERO_WORD;
    case (mmio_ofs)
      MMIO_LED_OFS: mmio_rdata = {16'h0000, led_o};
      MMIO_SW_OFS:  mmio_rdata = {16'h0000, sw_i};
      MMIO_CNT_OFS: mmio_rdata = cycle_cnt;
      default:      mmio_rdata = ZERO_WORD;
    endcase
  end

  // LED register lane writes and free-running cycle counter cleared by any write
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      led_o     <= 16'h0000;
      cycle_cnt <= ZERO_WORD;
    end else begin
      if (wr_acc && is_mmio && (mmio_ofs == MMIO_LED_OFS)) begin
        if (sel_i[0]) led_o[7:0]  <= wdata_i[7:0];
        if (sel_i[1]) led_o[15:8] <= wdata_i[15:8];
      end
      if (wr_acc && is_mmio && (mmio_ofs == MMIO_CNT_OFS)) begin
        cycle_cnt <= ZERO_WORD;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end
`else
  assign is_mmio    = 1'b0;
  assign mmio_rdata = ZERO_WORD;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (AW=10, READ_LAT=2).
// Inputs are driven at the falling edge and outputs sampled 1 ns later.
module tb_data_mem_responder;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n   = 1'b1;
  logic        ce_i        = 1'b0;
  logic        we_i        = 1'b0;
  logic [3:0]  sel_i       = 4'h0;
  logic [31:0] addr_i      = 32'h0;
  logic [31:0] wdata_i     = 32'h0;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        addr_err_o;
`ifdef DMEM_MMIO_EN
  logic [15:0] led_o;
  logic [15:0] sw_i = 16'h00F0;
  localparam logic [31:0] MMIO_BASE = 32'h1FAF_0000;
`endif

  int vec_count   = 0;
  int miscompares = 0;

  data_mem_responder #(.AW(10), .READ_LAT(2)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .ce_i        (ce_i),
    .we_i        (we_i),
    .sel_i       (sel_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .addr_err_o  (addr_err_o)
`ifdef DMEM_MMIO_EN
    ,
    .led_o       (led_o),
    .sw_i        (sw_i)
`endif
  );

  // 50 MHz-style free-running clock, 10 ns period
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic we, input logic [3:0] sel,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge cpu_clk_50M);
    ce_i    = ce;
    we_i    = we;
    sel_i   = sel;
    addr_i  = addr;
    wdata_i = wdata;
    #1;
  endtask

  task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input logic exp_err);
    applyStimulus(1'b1, 1'b1, sel, addr, data);
    checkOutput({tag, " stall"}, {31'b0, stall_o}, 32'd0);
    checkOutput({tag, " err"}, {31'b0, addr_err_o}, {31'b0, exp_err});
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err);
    applyStimulus(1'b1, 1'b0, 4'h0, addr, 32'h0);
    checkOutput({tag, " stall c0"}, {31'b0, stall_o}, 32'd1);
    checkOutput({tag, " err c0"}, {31'b0, addr_err_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'h0, addr, 32'h0);
    checkOutput({tag, " stall c1"}, {31'b0, stall_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h0, addr, 32'h0);
    checkOutput({tag, " stall resp"}, {31'b0, stall_o}, 32'd0);
    checkOutput({tag, " rdata"}, rdata_o, exp_data);
    checkOutput({tag, " err resp"}, {31'b0, addr_err_o}, {31'b0, exp_err});
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput({tag, " err after"}, {31'b0, addr_err_o}, 32'd0);
    checkOutput({tag, " rdata hold"}, rdata_o, exp_data);
  endtask

  initial begin
    #2 cpu_rst_n = 1'b0;
    repeat (2) @(negedge cpu_clk_50M);
    #1;
    checkOutput("reset rdata", rdata_o, 32'h0);
    checkOutput("reset stall", {31'b0, stall_o}, 32'd0);
    checkOutput("reset err", {31'b0, addr_err_o}, 32'd0);
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;

    // Full write then read-after-write of the same word
    doWrite("wr full", 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    doRead("rd full", 32'h10, 32'hDEAD_BEEF, 1'b0);

    // Single lane update and an all-lanes-disabled no-op
    doWrite("wr lane1", 32'h10, 32'h0000_AA00, 4'b0010, 1'b0);
    doRead("rd lane1", 32'h10, 32'hDEAD_AAEF, 1'b0);
    doWrite("wr sel0", 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    doRead("rd sel0", 32'h10, 32'hDEAD_AAEF, 1'b0);
    doWrite("wr w5", 32'h14, 32'h1234_5678, 4'b1111, 1'b0);
    doRead("rd w5", 32'h14, 32'h1234_5678, 1'b0);

    // Back-to-back: ce_i still high the cycle after RESP starts a new read
    doRead("b2b first", 32'h10, 32'hDEAD_AAEF, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    checkOutput("b2b resp1 rdata", rdata_o, 32'hDEAD_AAEF);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    checkOutput("b2b new req stall", {31'b0, stall_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    checkOutput("b2b wait stall", {31'b0, stall_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    checkOutput("b2b resp2 stall", {31'b0, stall_o}, 32'd0);
    checkOutput("b2b resp2 rdata", rdata_o, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Flush: ce_i dropped in the first WAIT cycle discards the read
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    checkOutput("flush issue stall", {31'b0, stall_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h10, 32'h0);
    checkOutput("flush stall", {31'b0, stall_o}, 32'd0);
    checkOutput("flush rdata", rdata_o, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("flush idle rdata", rdata_o, 32'h1234_5678);
    doRead("post flush", 32'h10, 32'hDEAD_AAEF, 1'b0);

    // Out-of-range: read returns zero with an error pulse, write is dropped
    doWrite("wr w0", 32'h0, 32'hCAFE_F00D, 4'b1111, 1'b0);
    doRead("rd oor", 32'h0000_1000, 32'h0, 1'b1);
    doWrite("wr oor", 32'h0000_1000, 32'h1111_1111, 4'b1111, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("wr oor pulse end", {31'b0, addr_err_o}, 32'd0);
    doRead("rd w0 intact", 32'h0, 32'hCAFE_F00D, 1'b0);

    // Outer lanes only
    doWrite("wr lanes03", 32'h10, 32'h1100_0022, 4'b1001, 1'b0);
    doRead("rd lanes03", 32'h10, 32'h11AD_AA22, 1'b0);

    // Reset in the middle of WAIT with the request still held
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    checkOutput("pre reset stall", {31'b0, stall_o}, 32'd1);
    cpu_rst_n = 1'b0;
    #1;
    checkOutput("mid reset stall", {31'b0, stall_o}, 32'd0);
    checkOutput("mid reset rdata", rdata_o, 32'h0);
    checkOutput("mid reset err", {31'b0, addr_err_o}, 32'd0);
    @(negedge cpu_clk_50M);
    ce_i      = 1'b0;
    cpu_rst_n = 1'b1;
    doRead("post reset", 32'h10, 32'h11AD_AA22, 1'b0);

`ifdef DMEM_MMIO_EN
    // MMIO window: LED register, switches, cycle counter, unmapped offset
    doWrite("wr led", MMIO_BASE, 32'h0000_5A5A, 4'b0011, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("led value", {16'h0, led_o}, 32'h0000_5A5A);
    doRead("rd led", MMIO_BASE, 32'h0000_5A5A, 1'b0);
    doRead("rd sw", MMIO_BASE + 32'h4, 32'h0000_00F0, 1'b0);
    doWrite("clr cnt a", MMIO_BASE + 32'h8, 32'h0, 4'b1111, 1'b0);
    doRead("rd cnt 1", MMIO_BASE + 32'h8, 32'd1, 1'b0);
    doWrite("clr cnt b", MMIO_BASE + 32'h8, 32'h0, 4'b1111, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    doRead("rd cnt 6", MMIO_BASE + 32'h8, 32'd6, 1'b0);
    doRead("rd unmapped", MMIO_BASE + 32'hC, 32'h0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
